// File: rtl/fetch_pkg.sv
// Shared types and constants for the Wishbone instruction-fetch master.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic {
    StIdle,
    StReq
  } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO holding {instr, pc} pairs; head is read straight from flops.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/fetch_wb.sv
// Wishbone classic instruction-fetch master: sequential word reads, prefetch FIFO, redirect/flush.
module fetch_wb
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] wbm_adr_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  input  logic            wbm_ack_i,
  input  logic [XLEN-1:0] wbm_dat_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  input  logic            ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned FifoW = 2 * XLEN;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            stale_q;

  logic [CntW-1:0]  fifo_count, cnt_next;
  logic [FifoW-1:0] fifo_rdata;
  logic             fifo_empty, unused_full;
  logic             push, pop, credit;
  logic [XLEN-1:0]  redir_pc, next_fetch_pc;
  logic             unused_pc_bits;

  assign redir_pc       = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  assign push = (state_q == StReq) & wbm_ack_i & ~stale_q & ~redirect_i;
  assign pop  = ~fifo_empty & ready_i & ~redirect_i;

  // Occupancy after this edge; one slot must stay free for the word we are about to request.
  always_comb begin
    cnt_next = fifo_count;
    if (redirect_i) cnt_next = '0;
    else if (push && !pop) cnt_next = fifo_count + CntW'(1);
    else if (pop && !push) cnt_next = fifo_count - CntW'(1);
  end

  assign credit = (cnt_next < CntW'(DEPTH));

  always_comb begin
    next_fetch_pc = pc_q;
    if (redirect_i) next_fetch_pc = redir_pc;
    else if (push) next_fetch_pc = pc_q + XLEN'(WORD_BYTES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      stale_q   <= 1'b0;
      wbm_adr_o <= RESET_PC;
      wbm_cyc_o <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pc_q <= next_fetch_pc;
          if (!redirect_i && credit) begin
            state_q   <= StReq;
            wbm_cyc_o <= 1'b1;
            wbm_adr_o <= pc_q;
          end
        end
        StReq: begin
          if (wbm_ack_i) begin
            // Stale or redirected data is dropped; either way the cycle ends here.
            stale_q <= 1'b0;
            pc_q    <= next_fetch_pc;
            if (credit) begin
              wbm_adr_o <= next_fetch_pc;
            end else begin
              state_q   <= StIdle;
              wbm_cyc_o <= 1'b0;
            end
          end else if (redirect_i) begin
            // A classic cycle cannot be aborted: finish it, then throw the data away.
            stale_q <= 1'b1;
            pc_q    <= redir_pc;
          end
        end
        default: begin
          state_q   <= StIdle;
          wbm_cyc_o <= 1'b0;
        end
      endcase
    end
  end

  assign wbm_stb_o = wbm_cyc_o;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FifoW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata ({wbm_dat_i, wbm_adr_o}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (unused_full),
    .empty (fifo_empty)
  );

  assign instr_o = fifo_rdata[FifoW-1:XLEN];
  assign pc_o    = fifo_rdata[XLEN-1:0];
  assign valid_o = ~fifo_empty;

endmodule

// File: tb/tb_fetch_wb.sv
// Directed bench for fetch_wb against a one-wait-state ROM slave with rom[i] = A000_0000 + i.
module tb_fetch_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr, dat, instr, pc, redirect_pc;
  logic        cyc, stb, ack, valid, ready, redirect, hold_ack;
  logic [31:0] adr2, instr2, pc2;
  logic        cyc2, stb2, valid2;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ack_cnt  = 0;
  logic [31:0] mon_pc[$];
  logic [31:0] mon_ins[$];
  time         mon_t[$];

  always #5 clk = ~clk;

  fetch_wb #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .wbm_adr_o(adr), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
    .wbm_ack_i(ack), .wbm_dat_i(dat), .instr_o(instr), .pc_o(pc), .valid_o(valid),
    .ready_i(ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  fetch_wb #(.RESET_PC(32'h0000_0040), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .wbm_adr_o(adr2), .wbm_cyc_o(cyc2), .wbm_stb_o(stb2),
    .wbm_ack_i(1'b0), .wbm_dat_i(32'h0), .instr_o(instr2), .pc_o(pc2), .valid_o(valid2),
    .ready_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(32'h0)
  );

  // ROM slave: registered ack one cycle after strobe, never two acks in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0;
      dat <= 32'h0;
    end else begin
      ack <= cyc & stb & ~ack & ~hold_ack;
      dat <= 32'hA000_0000 + {2'b00, adr[31:2]};
    end
  end

  always @(posedge clk) begin
    if (!rst && valid && ready && !redirect) begin
      mon_pc.push_back(pc);
      mon_ins.push_back(instr);
      mon_t.push_back($time);
    end
    if (!rst && cyc && ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic apply_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1; ready = rdy; redirect = 1'b0; redirect_pc = 32'h0; hold_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; hold_ack = 1'b0;
    #1;
    n_checks++; if (cyc !== 1'b0) $display("FAIL rst_cyc got %b want 0", cyc); else n_pass++;
    n_checks++; if (stb !== 1'b0) $display("FAIL rst_stb got %b want 0", stb); else n_pass++;
    n_checks++; if (adr !== 32'h0) $display("FAIL rst_adr got %h want 0", adr); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL rst_valid got %b want 0", valid); else n_pass++;
    n_checks++; if ({instr, pc} !== 64'h0) $display("FAIL rst_head got %h/%h want 0", instr, pc);
    else n_pass++;
    n_checks++; if (adr2 !== 32'h40 || cyc2 !== 1'b0 || valid2 !== 1'b0 || pc2 !== 32'h0 ||
                    instr2 !== 32'h0)
      $display("FAIL rst_adr_param got %h cyc %b want 40 cyc 0", adr2, cyc2);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cyc !== 1'b1 || stb !== 1'b1 || adr !== 32'h0 || valid !== 1'b0)
      $display("FAIL first_req got cyc %b adr %h valid %b want 1 0 0", cyc, adr, valid);
    else n_pass++;
    n_checks++; if (cyc2 !== 1'b1 || stb2 !== 1'b1 || adr2 !== 32'h40)
      $display("FAIL first_req_param got cyc %b adr %h want 1 40", cyc2, adr2);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (ack !== 1'b1 || valid !== 1'b0)
      $display("FAIL ack_cycle got ack %b valid %b want 1 0", ack, valid);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'hA000_0000 || adr !== 32'h4)
      $display("FAIL first_valid got v %b pc %h ins %h adr %h want 1 0 a0000000 4",
               valid, pc, instr, adr);
    else n_pass++;
  endtask

  task automatic test_stream;
    int base;
    base = 0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (mon_pc.size() < base + 3) $display("FAIL stream_count got %0d want 3", mon_pc.size());
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (mon_pc[base+i] !== 32'(4 * i) || mon_ins[base+i] !== 32'hA000_0000 + 32'(i))
          $display("FAIL stream_word%0d got %h/%h want %h/%h", i, mon_pc[base+i],
                   mon_ins[base+i], 32'(4 * i), 32'hA000_0000 + 32'(i));
        else n_pass++;
      end
      n_checks++;
      if (mon_t[base+1] - mon_t[base] !== 64'd20 || mon_t[base+2] - mon_t[base+1] !== 64'd20)
        $display("FAIL stream_rate got %0t %0t want 20 20", mon_t[base+1] - mon_t[base],
                 mon_t[base+2] - mon_t[base+1]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    int a0, base;
    apply_reset(1'b0);
    a0 = ack_cnt;
    repeat (20) @(negedge clk);
    n_checks++; if (ack_cnt - a0 !== 2) $display("FAIL bp_acks got %0d want 2", ack_cnt - a0);
    else n_pass++;
    n_checks++; if (cyc !== 1'b0 || valid !== 1'b1 || pc !== 32'h0)
      $display("FAIL bp_idle got cyc %b valid %b pc %h want 0 1 0", cyc, valid, pc);
    else n_pass++;
    base = mon_pc.size();
    ready = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (mon_pc.size() < base + 4) $display("FAIL bp_resume_count got %0d want 4",
                                           mon_pc.size() - base);
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (mon_pc[base+i] !== 32'(4 * i))
          $display("FAIL bp_resume_pc%0d got %h want %h", i, mon_pc[base+i], 32'(4 * i));
        else n_pass++;
      end
    end
  endtask

  task automatic wait_for_req(input logic [31:0] a, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (cyc && adr == a && !ack) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL %s_wait got timeout want req at %h", name, a);
    else n_pass++;
  endtask

  task automatic wait_valid(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (valid) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!found) $display("FAIL %s_valid got timeout want valid", name);
    else n_pass++;
  endtask

  task automatic test_redirect_stale;
    int base;
    bit moved;
    apply_reset(1'b1);
    wait_for_req(32'h10, "stale");
    base = mon_pc.size();
    hold_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++; if (cyc !== 1'b1 || adr !== 32'h10 || valid !== 1'b0)
      $display("FAIL stale_hold got cyc %b adr %h valid %b want 1 10 0", cyc, adr, valid);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (cyc !== 1'b1 || adr !== 32'h10)
      $display("FAIL stale_hold2 got cyc %b adr %h want 1 10", cyc, adr);
    else n_pass++;
    hold_ack = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 10 && !moved; i++) begin
      @(negedge clk);
      if (adr != 32'h10) moved = 1'b1;
    end
    n_checks++; if (adr !== 32'h100 || cyc !== 1'b1)
      $display("FAIL stale_next_adr got %h cyc %b want 100 1", adr, cyc);
    else n_pass++;
    wait_valid("stale");
    n_checks++; if (pc !== 32'h100 || instr !== 32'hA000_0040)
      $display("FAIL stale_first got %h/%h want 100/a0000040", pc, instr);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (mon_pc.size() <= base || mon_pc[base] !== 32'h100)
      $display("FAIL stale_first_pop got %0d entries want pc 100 first", mon_pc.size() - base);
    else n_pass++;
  endtask

  task automatic test_redirect_ack;
    int base;
    bit found;
    apply_reset(1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cyc && ack && valid) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rack_wait got timeout want ack with valid");
    else n_pass++;
    base = mon_pc.size();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0203;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++; if (valid !== 1'b0 || cyc !== 1'b1 || adr !== 32'h200)
      $display("FAIL rack_flush got valid %b cyc %b adr %h want 0 1 200", valid, cyc, adr);
    else n_pass++;
    n_checks++; if (mon_pc.size() !== base)
      $display("FAIL rack_no_pop got %0d pops want 0", mon_pc.size() - base);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) $display("FAIL rack_empty got %b want 0", valid);
    else n_pass++;
    wait_valid("rack");
    n_checks++; if (pc !== 32'h200 || instr !== 32'hA000_0080)
      $display("FAIL rack_first got %h/%h want 200/a0000080", pc, instr);
    else n_pass++;
  endtask

  task automatic test_double_redirect;
    int base;
    apply_reset(1'b1);
    wait_for_req(32'h8, "dbl");
    base = mon_pc.size();
    hold_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++; if (cyc !== 1'b1 || adr !== 32'h8)
      $display("FAIL dbl_hold got cyc %b adr %h want 1 8", cyc, adr);
    else n_pass++;
    hold_ack = 1'b0;
    wait_valid("dbl");
    n_checks++; if (pc !== 32'h300 || instr !== 32'hA000_00C0)
      $display("FAIL dbl_first got %h/%h want 300/a00000c0", pc, instr);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (mon_pc.size() <= base || mon_pc[base] !== 32'h300)
      $display("FAIL dbl_first_pop got %0d entries want pc 300 first", mon_pc.size() - base);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit found;
    apply_reset(1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cyc && valid) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL mid_wait got timeout want cyc with valid");
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (cyc !== 1'b0 || stb !== 1'b0 || valid !== 1'b0 || adr !== 32'h0)
      $display("FAIL mid_async got cyc %b stb %b valid %b adr %h want 0 0 0 0",
               cyc, stb, valid, adr);
    else n_pass++;
    n_checks++; if (cyc2 !== 1'b0 || adr2 !== 32'h40)
      $display("FAIL mid_async_param got cyc %b adr %h want 0 40", cyc2, adr2);
    else n_pass++;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (cyc !== 1'b1 || adr !== 32'h0)
      $display("FAIL mid_restart got cyc %b adr %h want 1 0", cyc, adr);
    else n_pass++;
  endtask

  task automatic test_wrap;
    int base;
    bit done;
    apply_reset(1'b1);
    wait_for_req(32'h4, "wrap");
    base = mon_pc.size();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (mon_pc.size() >= base + 2) done = 1'b1;
    end
    n_checks++;
    if (!done) $display("FAIL wrap_count got %0d want 2", mon_pc.size() - base);
    else begin
      n_pass++;
      n_checks++; if (mon_pc[base] !== 32'hFFFF_FFFC || mon_ins[base] !== 32'hDFFF_FFFF)
        $display("FAIL wrap_top got %h/%h want fffffffc/dfffffff", mon_pc[base], mon_ins[base]);
      else n_pass++;
      n_checks++; if (mon_pc[base+1] !== 32'h0 || mon_ins[base+1] !== 32'hA000_0000)
        $display("FAIL wrap_zero got %h/%h want 0/a0000000", mon_pc[base+1], mon_ins[base+1]);
      else n_pass++;
    end
  endtask

  initial begin
    ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; hold_ack = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_stale;
    test_redirect_ack;
    test_double_redirect;
    test_reset_mid;
    test_wrap;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
